// File: rtl/serial_word_scheduler.sv
// Queues transmit/receive commands for a serial word core, sequences its
// start/busy handshake, and buffers received words in a first-word-fall-through FIFO.
module serial_word_scheduler #(
  parameter int DATA_WIDTH_BASE = 5,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int START_CYCLES    = 2,
  parameter int BUSY_TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_wr_en,
  input  logic                            cmd_mode,
  input  logic [2**DATA_WIDTH_BASE-1:0]   cmd_data,
  output logic                            cmd_full,
  input  logic                            rx_rd_en,
  output logic [2**DATA_WIDTH_BASE-1:0]   rx_rd_data,
  output logic                            rx_empty,
  output logic                            core_start,
  output logic                            core_mode,
  output logic [2**DATA_WIDTH_BASE-1:0]   core_transmit_data,
  input  logic                            core_busy,
  input  logic [2**DATA_WIDTH_BASE-1:0]   core_receive_data,
  output logic                            idle,
  output logic                            timeout_err,
  output logic                            cmd_overflow
);

  localparam int W     = 2**DATA_WIDTH_BASE;
  localparam int L     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 2**FIFO_DEPTH_LOG2;
  localparam int CNT_W = $clog2(START_CYCLES + BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef logic [L:0] ptr_t;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_CAPTURE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [W:0]   cmd_mem [DEPTH];
  logic [W-1:0] rx_mem  [DEPTH];
  ptr_t         cmd_wr_ptr, cmd_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic         cmd_empty, rx_full;
  logic         cmd_push, cmd_pop, rx_push, rx_pop;

  // The extra MSB on each pointer distinguishes full from empty when the indices match.
  assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
  assign cmd_full  = (cmd_wr_ptr[L] != cmd_rd_ptr[L]) && (cmd_wr_ptr[L-1:0] == cmd_rd_ptr[L-1:0]);
  assign rx_empty  = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full   = (rx_wr_ptr[L] != rx_rd_ptr[L]) && (rx_wr_ptr[L-1:0] == rx_rd_ptr[L-1:0]);

  assign cmd_push = cmd_wr_en && !cmd_full;
  assign cmd_pop  = (state == S_IDLE) && !cmd_empty;
  // A read on a full RX FIFO frees the slot in the same cycle, so the capture may proceed.
  assign rx_push  = (state == S_CAPTURE) && core_mode && (!rx_full || rx_rd_en);
  assign rx_pop   = rx_rd_en && !rx_empty;

  assign rx_rd_data = rx_empty ? '0 : rx_mem[rx_rd_ptr[L-1:0]];
  assign idle       = (state == S_IDLE) && cmd_empty;

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr[L-1:0]] <= {cmd_mode, cmd_data};
    if (rx_push)  rx_mem[rx_wr_ptr[L-1:0]]   <= core_receive_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      if (rx_push)  rx_wr_ptr  <= rx_wr_ptr + 1'b1;
      if (rx_pop)   rx_rd_ptr  <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      cnt                <= '0;
      core_start         <= 1'b0;
      core_mode          <= 1'b0;
      core_transmit_data <= '0;
      timeout_err        <= 1'b0;
      cmd_overflow       <= 1'b0;
    end else begin
      if (cmd_wr_en && cmd_full) cmd_overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_pop) begin
            {core_mode, core_transmit_data} <= cmd_mem[cmd_rd_ptr[L-1:0]];
            core_start <= 1'b1;
            cnt        <= '0;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (cnt == START_LAST) begin
            core_start <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT_BUSY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (core_busy) begin
            state <= S_RUN;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!core_busy) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Receive captures hold here while the RX FIFO has no room.
          if (!core_mode || rx_push) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_scheduler.sv
// Directed bench for serial_word_scheduler: a behavioural serial core plus
// scoreboard queues for expected launches and expected received words.
module tb_serial_word_scheduler;

  localparam int W            = 32;
  localparam int START_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_wr_en = 1'b0;
  logic         cmd_mode = 1'b0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_full;
  logic         rx_rd_en = 1'b0;
  logic [W-1:0] rx_rd_data;
  logic         rx_empty;
  logic         core_start, core_mode;
  logic [W-1:0] core_transmit_data;
  logic         core_busy = 1'b0;
  logic [W-1:0] core_receive_data = '0;
  logic         idle, timeout_err, cmd_overflow;

  serial_word_scheduler dut (
    .clk(clk), .rst(rst),
    .cmd_wr_en(cmd_wr_en), .cmd_mode(cmd_mode), .cmd_data(cmd_data), .cmd_full(cmd_full),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
    .core_start(core_start), .core_mode(core_mode), .core_transmit_data(core_transmit_data),
    .core_busy(core_busy), .core_receive_data(core_receive_data),
    .idle(idle), .timeout_err(timeout_err), .cmd_overflow(cmd_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0]   exp_launch [$];
  logic [W-1:0] exp_rx     [$];
  logic [W-1:0] ret_q      [$];
  int           launches = 0;
  bit           core_respond = 1'b1;
  bit           core_stall   = 1'b0;
  int           busy_len     = 3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    n_checks++;
    assert (cond) else begin
      n_fail++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  // Behavioural serial core: responds to a start pulse with a busy window and
  // presents the next queued receive word; also scores each launch.
  logic       start_q = 1'b0;
  int         start_len = 0;
  int         busy_cnt = 0;
  bit         pending = 1'b0;
  logic [W:0] launch_cmd = '0;

  always @(negedge clk) begin
    if (!rst) begin
      start_q = 1'b0; start_len = 0; pending = 1'b0; busy_cnt = 0; core_busy = 1'b0;
    end else begin
      if (core_start) begin
        if (!start_q) begin
          launches++;
          launch_cmd = {core_mode, core_transmit_data};
          check_true("launch_was_expected", exp_launch.size() > 0);
          if (exp_launch.size() > 0) check("launch_cmd", launch_cmd, exp_launch.pop_front());
          if (core_respond) begin
            pending  = 1'b1;
            busy_cnt = busy_len;
            if (core_mode && ret_q.size() > 0) core_receive_data = ret_q.pop_front();
          end
        end
        start_len++;
      end else if (start_q) begin
        check("start_len", start_len, START_CYCLES);
        start_len = 0;
      end
      if (pending && !core_start) begin
        core_busy = 1'b1;
        pending   = 1'b0;
      end else if (core_busy) begin
        if (busy_cnt > 1) busy_cnt--;
        else if (!core_stall) begin
          core_busy = 1'b0;
          check("mode_data_stable", {core_mode, core_transmit_data}, launch_cmd);
        end
      end
      start_q = core_start;
    end
  end

  task automatic write_cmd(input logic mode, input logic [W-1:0] data);
    cmd_wr_en = 1'b1; cmd_mode = mode; cmd_data = data;
    @(negedge clk);
    cmd_wr_en = 1'b0;
  endtask

  // sel: 0 = idle, 1 = core_busy, 2 = core_start
  task automatic wait_for(input int sel, input logic val, input int budget, input string tag);
    logic cur;
    bit   hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cur = (sel == 0) ? idle : (sel == 1) ? core_busy : core_start;
      if (cur === val) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check_true(tag, hit);
  endtask

  task automatic rx_pop(input string tag);
    logic [W-1:0] exp;
    check(tag, rx_empty, 1'b0);
    exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 'x;
    check(tag, rx_rd_data, exp);
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
  endtask

  initial begin
    int base;
    logic [W-1:0] w;

    // Reset state, checked before any clock edge.
    rst = 1'b0;
    #1;
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_mode", core_mode, 1'b0);
    check("rst_core_tx", core_transmit_data, 32'h0);
    check("rst_rx_rd_data", rx_rd_data, 32'h0);
    check("rst_cmd_full", cmd_full, 1'b0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_idle", idle, 1'b1);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_cmd_overflow", cmd_overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Transmit command with a 70-cycle busy window; also checks write-to-start latency.
    busy_len = 70;
    exp_launch.push_back({1'b0, 32'h56D01953});
    write_cmd(1'b0, 32'h56D01953);
    check("lat_start_n1", core_start, 1'b0);
    check("lat_not_idle", idle, 1'b0);
    @(negedge clk);
    check("lat_start_n2", core_start, 1'b1);
    check("tx_data", core_transmit_data, 32'h56D01953);
    wait_for(0, 1'b1, 300, "tx_idle_return");
    check("tx_rx_empty", rx_empty, 1'b1);
    check("tx_launch_count", launches, 1);

    // Receive command: word appears at the RX head, one read empties it.
    busy_len = 3;
    exp_launch.push_back({1'b1, 32'hDEADBEEF});
    ret_q.push_back(32'h56D01953);
    exp_rx.push_back(32'h56D01953);
    write_cmd(1'b1, 32'hDEADBEEF);
    wait_for(0, 1'b1, 100, "rx_idle_return");
    rx_pop("rx_word");
    check("rx_empty_after_read", rx_empty, 1'b1);

    // Command FIFO fills while the core is stalled in busy; fifth write dropped.
    core_stall = 1'b1;
    base = launches;
    exp_launch.push_back({1'b0, 32'h0BAD_F00D});
    write_cmd(1'b0, 32'h0BAD_F00D);
    wait_for(1, 1'b1, 50, "stall_busy_seen");
    for (int i = 0; i < 4; i++) begin
      exp_launch.push_back({1'b0, 32'h1000_0000 + 32'(i)});
      write_cmd(1'b0, 32'h1000_0000 + 32'(i));
    end
    check("full_after_4", cmd_full, 1'b1);
    check("no_overflow_yet", cmd_overflow, 1'b0);
    write_cmd(1'b0, 32'h1000_0004);
    check("overflow_set", cmd_overflow, 1'b1);
    check("full_held", cmd_full, 1'b1);
    core_stall = 1'b0;
    wait_for(0, 1'b1, 500, "drain_idle");
    check("drain_launches", launches - base, 5);
    check("drain_all_seen", exp_launch.size(), 0);

    // Five receive commands with no reads: RX fills, the fifth capture stalls.
    base = launches;
    for (int i = 0; i < 5; i++) begin
      w = 32'hA000_0000 + 32'(i * 17);
      exp_launch.push_back({1'b1, 32'h5000_0000 + 32'(i)});
      ret_q.push_back(w);
      exp_rx.push_back(w);
      write_cmd(1'b1, 32'h5000_0000 + 32'(i));
    end
    repeat (200) @(negedge clk);
    check("rxfull_launches", launches - base, 5);
    check("rxfull_stalled", idle, 1'b0);
    check("rxfull_not_busy", core_busy, 1'b0);
    check("rxfull_no_start", core_start, 1'b0);
    check("rxfull_head", rx_rd_data, exp_rx[0]);
    rx_pop("rxfull_pop0");
    wait_for(0, 1'b1, 20, "rxfull_release");
    for (int i = 0; i < 4; i++) rx_pop("rxfull_pop");
    check("rxfull_drained", rx_empty, 1'b1);
    // Read while empty must be ignored.
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
    check("rd_empty_ignored", rx_empty, 1'b1);

    // Core never answers the first launch: timeout after 16 cycles, then next command runs.
    core_respond = 1'b0;
    exp_launch.push_back({1'b0, 32'h7777_0001});
    exp_launch.push_back({1'b0, 32'h7777_0002});
    write_cmd(1'b0, 32'h7777_0001);
    write_cmd(1'b0, 32'h7777_0002);
    wait_for(2, 1'b1, 20, "to_start_seen");
    wait_for(2, 1'b0, 20, "to_start_end");
    core_respond = 1'b1;
    repeat (15) @(negedge clk);
    check("timeout_not_yet", timeout_err, 1'b0);
    @(negedge clk);
    check("timeout_set", timeout_err, 1'b1);
    wait_for(0, 1'b1, 100, "to_next_done");
    check("to_all_seen", exp_launch.size(), 0);
    check("timeout_sticky", timeout_err, 1'b1);

    // Asynchronous reset during RUN with data held in both FIFOs.
    exp_launch.push_back({1'b1, 32'h0000_0042});
    ret_q.push_back(32'hA5A5_0001);
    exp_rx.push_back(32'hA5A5_0001);
    write_cmd(1'b1, 32'h0000_0042);
    wait_for(0, 1'b1, 100, "pre_rst_idle");
    check("pre_rst_rx_head", rx_rd_data, exp_rx[0]);
    core_stall = 1'b1;
    exp_launch.push_back({1'b0, 32'hC0DE_0001});
    write_cmd(1'b0, 32'hC0DE_0001);
    wait_for(1, 1'b1, 50, "pre_rst_busy");
    write_cmd(1'b0, 32'hC0DE_0002);
    repeat (3) @(negedge clk);
    check("pre_rst_overflow", cmd_overflow, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_core_start", core_start, 1'b0);
    check("arst_rx_empty", rx_empty, 1'b1);
    check("arst_cmd_full", cmd_full, 1'b0);
    check("arst_timeout_err", timeout_err, 1'b0);
    check("arst_cmd_overflow", cmd_overflow, 1'b0);
    check("arst_idle", idle, 1'b1);
    exp_launch.delete();
    exp_rx.delete();
    ret_q.delete();
    core_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = launches;
    repeat (5) @(negedge clk);
    check("post_rst_no_launch", launches - base, 0);
    exp_launch.push_back({1'b0, 32'hFACE_0001});
    write_cmd(1'b0, 32'hFACE_0001);
    wait_for(0, 1'b1, 100, "post_rst_idle");
    check("post_rst_launch", launches - base, 1);
    check("post_rst_all_seen", exp_launch.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
